inst_queue: RTL and testbench



---
 rtl/inst_queue_if.sv | 22 ++
 rtl/inst_queue.sv | 62 ++++++
 tb/tb_inst_queue.sv | 117 +++++++++++
 3 files changed

// File: rtl/inst_queue_if.sv
// inst_queue_if: fetch-side write ports, decode-side read ports and status of the instruction queue.
interface inst_queue_if #(parameter int DEPTH = 8);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] in1_pc, in1_npc, in1_inst;
  logic [31:0] in2_pc, in2_npc, in2_inst;
  logic [1:0]  in_issue;
  logic        flush;
  logic        stop;
  logic [31:0] out1_pc, out1_npc, out1_inst;
  logic [31:0] out2_pc, out2_npc, out2_inst;
  logic [1:0]  out_valid;
  logic [1:0]  id_take;
  logic [AW:0] count;
  modport master (
    output in1_pc, in1_npc, in1_inst, in2_pc, in2_npc, in2_inst, in_issue, flush, id_take,
    input  stop, out1_pc, out1_npc, out1_inst, out2_pc, out2_npc, out2_inst, out_valid, count
  );
  modport slave (
    input  in1_pc, in1_npc, in1_inst, in2_pc, in2_npc, in2_inst, in_issue, flush, id_take,
    output stop, out1_pc, out1_npc, out1_inst, out2_pc, out2_npc, out2_inst, out_valid, count
  );
endinterface

// File: rtl/inst_queue.sv
// inst_queue: dual-slot fetch-to-decode circular instruction queue with flush.
// Define INST_QUEUE_BYPASS_EN to pass instructions straight through an empty queue.
module inst_queue #(parameter int DEPTH = 8) (
  input logic clk,
  input logic rst_n,
  inst_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  typedef struct packed { logic [31:0] pc, npc, inst; } entry_t;
  entry_t        mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  entry_t        e0, e1, h0, h1, o0, o1, w0;
  logic [1:0]    n_in, n_take, n_wr, skip, deq, take_eff, valid;
  logic          byp, stop;
  always_comb begin
    e0 = q.in_issue[1] ? {q.in1_pc, q.in1_npc, q.in1_inst} : {q.in2_pc, q.in2_npc, q.in2_inst};
    e1 = {q.in2_pc, q.in2_npc, q.in2_inst};
    n_in = {1'b0, q.in_issue[1]} + {1'b0, q.in_issue[0]};
    h0 = mem_q[head_q];
    h1 = mem_q[head_q + AW'(1)];
`ifdef INST_QUEUE_BYPASS_EN
    byp = (count_q == '0) && !q.flush;
`else
    byp = 1'b0;
`endif
    stop = count_q > (AW+1)'(DEPTH - 2);
    valid = byp ? (n_in == 2'd0 ? 2'b00 : n_in == 2'd1 ? 2'b10 : 2'b11)
                : (count_q >= (AW+1)'(2) ? 2'b11 : count_q == (AW+1)'(1) ? 2'b10 : 2'b00);
    o0 = byp ? e0 : h0;
    o1 = byp ? e1 : h1;
    take_eff = q.id_take & valid;
    n_take = take_eff[1] ? (take_eff[0] ? 2'd2 : 2'd1) : 2'd0;
    // bypassed entries that decode takes this cycle never enter storage
    skip = byp ? n_take : 2'd0;
    deq = byp ? 2'd0 : n_take;
    n_wr = stop ? 2'd0 : n_in - skip;
    w0 = (skip == 2'd0) ? e0 : e1;
    head_d = q.flush ? '0 : head_q + AW'(deq);
    tail_d = q.flush ? '0 : tail_q + AW'(n_wr);
    count_d = q.flush ? '0 : count_q + (AW+1)'(n_wr) - (AW+1)'(deq);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      if (!q.flush && n_wr != 2'd0) mem_q[tail_q] <= w0;
      if (!q.flush && n_wr == 2'd2) mem_q[tail_q + AW'(1)] <= e1;
    end
  end
  assign q.stop = stop;
  assign q.count = count_q;
  assign q.out_valid = valid;
  assign {q.out1_pc, q.out1_npc, q.out1_inst} = o0;
  assign {q.out2_pc, q.out2_npc, q.out2_inst} = o1;
endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: directed plus random checks of inst_queue against a queue-of-entries reference model.
module tb_inst_queue;
  localparam int DEPTH = 8;
  typedef struct { logic [31:0] pc, npc, inst; } ent_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  ent_t mq[$];
  inst_queue_if #(.DEPTH(DEPTH)) ifc ();
  inst_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .q(ifc.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cycle(input logic [1:0] iss, input logic [1:0] tk, input logic fl,
                       input logic [31:0] p1, input logic [31:0] p2);
    ent_t in[$];
    ent_t v[$];
    ent_t e;
    int   nt;
    logic byp, st;
    ifc.in1_pc = p1; ifc.in1_npc = $urandom; ifc.in1_inst = $urandom;
    ifc.in2_pc = p2; ifc.in2_npc = $urandom; ifc.in2_inst = $urandom;
    ifc.in_issue = iss; ifc.id_take = tk; ifc.flush = fl;
    if (iss[1]) begin e.pc = ifc.in1_pc; e.npc = ifc.in1_npc; e.inst = ifc.in1_inst; in.push_back(e); end
    if (iss[0]) begin e.pc = ifc.in2_pc; e.npc = ifc.in2_npc; e.inst = ifc.in2_inst; in.push_back(e); end
    byp = 1'b0;
`ifdef INST_QUEUE_BYPASS_EN
    byp = (mq.size() == 0) && !fl;
`endif
    if (byp) v = in;
    else for (int i = 0; i < 2 && i < mq.size(); i++) v.push_back(mq[i]);
    st = (DEPTH - mq.size()) < 2;
    #1;
    chk("count", 32'(ifc.count), mq.size());
    chk("stop", 32'(ifc.stop), 32'(st));
    chk("out_valid", 32'(ifc.out_valid), v.size() >= 2 ? 2 'b11 : v.size() == 1 ? 32'b10 : 32'b00);
    if (v.size() > 0) begin
      chk("out1_pc", ifc.out1_pc, v[0].pc);
      chk("out1_npc", ifc.out1_npc, v[0].npc);
      chk("out1_inst", ifc.out1_inst, v[0].inst);
    end
    if (v.size() > 1) begin
      chk("out2_pc", ifc.out2_pc, v[1].pc);
      chk("out2_npc", ifc.out2_npc, v[1].npc);
      chk("out2_inst", ifc.out2_inst, v[1].inst);
    end
    nt = tk == 2'b11 ? 2 : tk == 2'b10 ? 1 : 0;
    if (nt > v.size()) nt = v.size();
    @(posedge clk);
    if (fl) mq.delete();
    else if (byp) begin
      for (int i = nt; i < in.size(); i++) mq.push_back(in[i]);
    end else begin
      for (int i = 0; i < nt; i++) mq.delete(0);
      if (!st) foreach (in[i]) mq.push_back(in[i]);
    end
    @(negedge clk);
  endtask
  initial begin
    ifc.in1_pc = '0; ifc.in1_npc = '0; ifc.in1_inst = '0;
    ifc.in2_pc = '0; ifc.in2_npc = '0; ifc.in2_inst = '0;
    ifc.in_issue = 2'b00; ifc.id_take = 2'b00; ifc.flush = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_count", 32'(ifc.count), 0);
    chk("rst_valid", 32'(ifc.out_valid), 0);
    chk("rst_stop", 32'(ifc.stop), 0);
    chk("rst_out1_pc", ifc.out1_pc, 0);
    chk("rst_out1_inst", ifc.out1_inst, 0);
    chk("rst_out2_npc", ifc.out2_npc, 0);
    rst_n = 1'b1;
    cycle(2'b11, 2'b00, 1'b0, 32'h0, 32'h4);
    cycle(2'b00, 2'b11, 1'b0, 32'h0, 32'h0);
    cycle(2'b01, 2'b00, 1'b0, 32'hdead, 32'h10);
    cycle(2'b00, 2'b10, 1'b0, 32'h0, 32'h0);
    cycle(2'b00, 2'b10, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) cycle(2'b11, 2'b00, 1'b0, 32'h40 + 8 * i, 32'h44 + 8 * i);
    cycle(2'b11, 2'b00, 1'b0, 32'hbad0, 32'hbad4);
    cycle(2'b10, 2'b11, 1'b0, 32'hbad8, 32'h0);
    cycle(2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
    ifc.in_issue = 2'b00; ifc.id_take = 2'b00;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_count", 32'(ifc.count), 0);
    chk("async_rst_valid", 32'(ifc.out_valid), 0);
    chk("async_rst_out1_pc", ifc.out1_pc, 0);
    mq.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle(2'b11, 2'b00, 1'b0, 32'h200 + 8 * i, 32'h204 + 8 * i);
    cycle(2'b10, 2'b00, 1'b0, 32'h218, 32'h0);
    for (int i = 0; i < 3; i++) cycle(2'b00, 2'b11, 1'b0, 32'h0, 32'h0);
    cycle(2'b11, 2'b00, 1'b0, 32'h100, 32'h104);
    cycle(2'b00, 2'b10, 1'b0, 32'h0, 32'h0);
    cycle(2'b00, 2'b11, 1'b0, 32'h0, 32'h0);
    cycle(2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
    cycle(2'b11, 2'b00, 1'b0, 32'h300, 32'h304);
    cycle(2'b11, 2'b00, 1'b0, 32'h308, 32'h30c);
    cycle(2'b10, 2'b00, 1'b0, 32'h310, 32'h0);
    cycle(2'b11, 2'b11, 1'b1, 32'hbad0, 32'hbad4);
    cycle(2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) cycle(2'b11, 2'b00, 1'b0, 32'h400 + 8 * i, 32'h404 + 8 * i);
    cycle(2'b11, 2'b00, 1'b1, 32'hbad0, 32'hbad4);
    cycle(2'b11, 2'b10, 1'b0, 32'h20, 32'h24);
    cycle(2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 400; i++)
      cycle(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom_range(0, 15) == 0, $urandom, $urandom);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
